// File: rtl/weight_preload_pkg.sv
// Shared parameters and state encoding for the weight pre-load controller.
// The optional transposed store is selected with the WEIGHT_PRELOAD_TRANSPOSE_EN macro.
package weight_preload_pkg;
    localparam int SIZE      = 8;
    localparam int DATA_W    = 5;
    localparam int ADDR_W    = 6;
    localparam int MEM_DEPTH = SIZE * SIZE;
    localparam int IDX_W     = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/weight_addr_gen.sv
// Row/column beat counter producing the weight memory write address.
// Defining WEIGHT_PRELOAD_TRANSPOSE_EN stores row-major input column-major.
module weight_addr_gen
    import weight_preload_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last_beat
);
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == IDX_W'(SIZE - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last_beat = (row == IDX_W'(SIZE - 1)) && (col == IDX_W'(SIZE - 1));

`ifdef WEIGHT_PRELOAD_TRANSPOSE_EN
    assign addr = ADDR_W'(col) * ADDR_W'(SIZE) + ADDR_W'(row);
`else
    assign addr = ADDR_W'(row) * ADDR_W'(SIZE) + ADDR_W'(col);
`endif
endmodule

// File: rtl/weight_preload_ctrl.sv
// Weight pre-load controller: accepts a valid/ready weight stream and writes it into the
// weight memory one cycle later (weight_done is the active-low write gate). Macro: WEIGHT_PRELOAD_TRANSPOSE_EN.
module weight_preload_ctrl
    import weight_preload_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_done,
    output logic              busy,
    output logic              load_complete,
    output logic              err
);
    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              enter_load;
    logic              last_beat;
    logic              frame_end;
    logic [ADDR_W-1:0] gen_addr;

    weight_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (enter_load),
        .inc       (accept),
        .addr      (gen_addr),
        .last_beat (last_beat)
    );

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        enter_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (last_beat || in_last)) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign frame_end = accept && (last_beat || in_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            weight_addr   <= '0;
            weight_data   <= '0;
            weight_done   <= 1'b1;
            load_complete <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q     <= state_d;
            weight_done <= !accept;
            if (accept) begin
                weight_addr <= gen_addr;
                weight_data <= in_data;
            end
            // Full-length frame sets load_complete; any mismatch between the count and in_last is a framing error.
            if (enter_load) begin
                load_complete <= 1'b0;
                err           <= 1'b0;
            end else if (frame_end) begin
                load_complete <= last_beat;
                err           <= last_beat ^ in_last;
            end
        end
    end
endmodule

// File: tb/tb_weight_preload_ctrl.sv
// Directed bench for weight_preload_ctrl: a vector table plus multi-cycle load sequences.
// Address expectations follow the WEIGHT_PRELOAD_TRANSPOSE_EN macro when it is defined.
module tb_weight_preload_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [5:0] weight_addr;
    logic [4:0] weight_data;
    logic       weight_done;
    logic       busy;
    logic       load_complete;
    logic       err;

    int checks = 0;
    int errors = 0;

    weight_preload_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .weight_addr   (weight_addr),
        .weight_data   (weight_data),
        .weight_done   (weight_done),
        .busy          (busy),
        .load_complete (load_complete),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       valid;
        logic [4:0] data;
        logic       last;
        logic       exp_ready;
        logic       exp_done;
        logic       exp_lc;
        logic       exp_err;
        logic [5:0] exp_addr;
        logic [4:0] exp_data;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    function automatic logic [5:0] exp_a(input int c);
`ifdef WEIGHT_PRELOAD_TRANSPOSE_EN
        return 6'((c % 8) * 8 + c / 8);
`else
        return 6'(c);
`endif
    endfunction

    function automatic vec_t mk(input logic s, input logic v, input logic [4:0] d, input logic l,
                                input logic r, input logic dn, input logic lc, input logic e,
                                input logic [5:0] a, input logic [4:0] wd);
        vec_t t;
        t.start = s; t.valid = v; t.data = d; t.last = l;
        t.exp_ready = r; t.exp_done = dn; t.exp_lc = lc; t.exp_err = e;
        t.exp_addr = a; t.exp_data = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, cross one rising edge, sample 1 time unit later.
    task automatic cyc(input logic s, input logic v, input logic [4:0] d, input logic l);
        start = s; in_valid = v; in_data = d; in_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic r, input logic dn, input logic lc, input logic e);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(r));
        chk({tag, ".busy"}, 32'(busy), 32'(r));
        chk({tag, ".weight_done"}, 32'(weight_done), 32'(dn));
        chk({tag, ".load_complete"}, 32'(load_complete), 32'(lc));
        chk({tag, ".err"}, 32'(err), 32'(e));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(0, 0, 5'd0, 0);
        cyc(0, 0, 5'd0, 0);
        rst = 1'b1;
    endtask

    // Full load from IDLE/DONE; last_at<0 means in_last is never raised.
    task automatic load_seq(input int last_at, input int gap_after, input int gap_len);
        int  i;
        bit  term;
        logic exp_lc, exp_err;
        cyc(1, 0, 5'd0, 0);
        chk_flags("ls.start", 1, 1, 0, 0);
        i = 0;
        term = 0;
        while (!term) begin
            term = (i == last_at) || (i == 63);
            cyc(0, 1, 5'(i % 32), i == last_at);
            chk("ls.addr", 32'(weight_addr), 32'(exp_a(i)));
            chk("ls.data", 32'(weight_data), 32'(i % 32));
            if (term) begin
                exp_lc  = (i == 63);
                exp_err = (i != 63) || (last_at != 63);
                chk_flags("ls.final", 0, 0, exp_lc, exp_err);
            end else begin
                chk_flags("ls.beat", 1, 0, 0, 0);
            end
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    cyc(0, 0, 5'd17, 0);
                    chk_flags("ls.gap", 1, 1, 0, 0);
                    chk("ls.gap_addr", 32'(weight_addr), 32'(exp_a(i)));
                end
            end
            i++;
        end
        cyc(0, 1, 5'd3, 0);
        chk_flags("ls.after", 0, 1, (i == 64), (i != 64) || (last_at != 63));
        chk("ls.after_addr", 32'(weight_addr), 32'(exp_a(i - 1)));
    endtask

    initial begin
        rst = 1'b0; start = 0; in_valid = 0; in_data = '0; in_last = 0;

        vecs[0] = mk(1, 1, 5'd7,  0, 1, 1, 0, 0, 6'd0,     5'd0);
        vecs[1] = mk(0, 1, 5'd3,  0, 1, 0, 0, 0, exp_a(0), 5'd3);
        vecs[2] = mk(0, 0, 5'd5,  0, 1, 1, 0, 0, exp_a(0), 5'd3);
        vecs[3] = mk(1, 1, 5'd9,  0, 1, 0, 0, 0, exp_a(1), 5'd9);
        vecs[4] = mk(0, 1, 5'd12, 1, 0, 0, 0, 1, exp_a(2), 5'd12);
        vecs[5] = mk(0, 1, 5'd4,  0, 0, 1, 0, 1, exp_a(2), 5'd12);
        vecs[6] = mk(1, 0, 5'd0,  0, 1, 1, 0, 0, exp_a(2), 5'd12);
        vecs[7] = mk(0, 1, 5'd31, 0, 1, 0, 0, 0, exp_a(0), 5'd31);

        do_reset();
        chk_flags("reset", 0, 1, 0, 0);
        chk("reset.addr", 32'(weight_addr), 32'd0);
        chk("reset.data", 32'(weight_data), 32'd0);

        for (int k = 0; k < NV; k++) begin
            cyc(vecs[k].start, vecs[k].valid, vecs[k].data, vecs[k].last);
            chk_flags($sformatf("vec%0d", k), vecs[k].exp_ready, vecs[k].exp_done,
                      vecs[k].exp_lc, vecs[k].exp_err);
            chk($sformatf("vec%0d.addr", k), 32'(weight_addr), 32'(vecs[k].exp_addr));
            chk($sformatf("vec%0d.data", k), 32'(weight_data), 32'(vecs[k].exp_data));
        end

        do_reset();
        load_seq(63, -1, 0);
        do_reset();
        load_seq(63, 10, 3);
        load_seq(20, -1, 0);
        load_seq(-1, -1, 0);

`ifdef WEIGHT_PRELOAD_TRANSPOSE_EN
        do_reset();
        cyc(1, 0, 5'd0, 0);
        cyc(0, 1, 5'd1, 0);
        cyc(0, 1, 5'd2, 0);
        chk("tr.beat1", 32'(weight_addr), 32'd8);
`endif

        // Reset mid-load after beat 30 cancels the next strobe.
        do_reset();
        cyc(1, 0, 5'd0, 0);
        for (int b = 0; b <= 30; b++) cyc(0, 1, 5'(b), 0);
        chk("rst.pre_addr", 32'(weight_addr), 32'(exp_a(30)));
        rst = 1'b0;
        cyc(0, 1, 5'd22, 0);
        rst = 1'b1;
        chk_flags("rst.cut", 0, 1, 0, 0);
        cyc(0, 1, 5'd23, 0);
        chk_flags("rst.idle", 0, 1, 0, 0);
        cyc(1, 1, 5'd24, 0);
        chk_flags("rst.start", 1, 1, 0, 0);
        cyc(0, 1, 5'd25, 0);
        chk_flags("rst.beat0", 1, 0, 0, 0);
        chk("rst.beat0_addr", 32'(weight_addr), 32'd0);
        chk("rst.beat0_data", 32'(weight_data), 32'd25);
        cyc(0, 0, 5'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
